// File: rtl/fe25519_pkg.sv
// fe25519_pkg
// Shared constants and types for arithmetic over GF(p), p = 2^255 - 19.
//   FE_W        field element width (255)
//   fe_t        one field element
//   P_25519     the modulus
//   P_MINUS_2   exponent used for Fermat inversion
//   reduce_once conditional subtraction of p on a 256-bit value
//   mul_state_t / inv_state_t  engine FSM encodings
package fe25519_pkg;

    localparam int FE_W = 255;

    typedef logic [FE_W-1:0] fe_t;

    // 2^255 - 19: all ones except the low five bits, which are 5'b01101.
    localparam fe_t P_25519   = {{250{1'b1}}, 5'b01101};
    // 2^255 - 21
    localparam fe_t P_MINUS_2 = {{250{1'b1}}, 5'b01011};

    typedef enum logic [1:0] {
        MUL_IDLE,
        MUL_RUN,
        MUL_FIN
    } mul_state_t;

    typedef enum logic [2:0] {
        INV_IDLE,
        INV_SQR,
        INV_SQR_WAIT,
        INV_MUL,
        INV_MUL_WAIT
    } inv_state_t;

    // One conditional subtraction of p. The carry bit is kept so that
    // values in [p, 2^256) can be chained through a second call.
    function automatic logic [FE_W:0] reduce_once(input logic [FE_W:0] x);
        logic [FE_W:0] p_ext;
        p_ext = {1'b0, P_25519};
        return (x >= p_ext) ? (x - p_ext) : x;
    endfunction

endpackage

// File: rtl/fe_mul_serial.sv
// fe_mul_serial
// Bit-serial modular multiplier: res = (a * b) mod p.
// MSB-first interleaved double-and-add over the 255 bits of b, one bit per
// cycle, followed by one publish/correction cycle.
//   clk, rst  clock, synchronous active-high reset
//   start     samples a/b and (re)starts; aborts any operation in flight
//   a, b      factors, any 255-bit value
//   res       fully reduced product, held until the next completion
//   valid     one-cycle completion pulse, 256 cycles after the start edge
//   state     FSM state (IDLE -> RUN x255 -> FIN -> IDLE)
//
// Handshake: start is a single-cycle request that is always accepted;
// valid is a single-cycle response that is only ever raised from FIN, and
// a start (or rst) in any cycle suppresses the pulse of the operation it
// replaces.
module fe_mul_serial
    import fe25519_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  fe_t        a,
    input  fe_t        b,
    output fe_t        res,
    output logic       valid,
    output mul_state_t state
);

    mul_state_t state_n;
    fe_t        a_r;
    fe_t        b_r;
    fe_t        acc;
    fe_t        acc_n;
    fe_t        dbl;
    fe_t        addend;
    logic [7:0] cnt;

    // acc stays in [0, p): 2*acc < 2p and dbl + a_r < 2p, so a single
    // conditional subtraction after each step is enough.
    always_comb begin
        dbl    = fe_t'(reduce_once({acc, 1'b0}));
        addend = b_r[FE_W-1] ? a_r : '0;
        acc_n  = fe_t'(reduce_once({1'b0, dbl} + {1'b0, addend}));
    end

    always_comb begin
        state_n = state;
        if (start) begin
            state_n = MUL_RUN;
        end else begin
            case (state)
                MUL_IDLE: state_n = MUL_IDLE;
                MUL_RUN:  state_n = (cnt == 8'd0) ? MUL_FIN : MUL_RUN;
                MUL_FIN:  state_n = MUL_IDLE;
                default:  state_n = MUL_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= MUL_IDLE;
            a_r   <= '0;
            b_r   <= '0;
            acc   <= '0;
            cnt   <= 8'd0;
            res   <= '0;
            valid <= 1'b0;
        end else begin
            state <= state_n;
            valid <= 1'b0;
            if (start) begin
                // a may be >= p; one subtraction brings it below p.
                a_r <= fe_t'(reduce_once({1'b0, a}));
                b_r <= b;
                acc <= '0;
                cnt <= 8'd254;
            end else if (state == MUL_RUN) begin
                acc <= acc_n;
                b_r <= {b_r[FE_W-2:0], 1'b0};
                cnt <= cnt - 8'd1;
            end else if (state == MUL_FIN) begin
                res   <= fe_t'(reduce_once({1'b0, acc}));
                valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/fe25519_arith.sv
// fe25519_arith
// GF(2^255 - 19) arithmetic unit: modular adder, bit-serial multiplier and
// Fermat inverter, running concurrently and independently.
//   clk, rst                  clock, synchronous active-high reset
//   add_start, add_a, add_b   start an addition (1-cycle latency)
//   add_res, add_valid        held sum, one-cycle completion pulse
//   mul_start, mul_a, mul_b   start a multiplication (256-cycle latency)
//   mul_res, mul_valid        held product, one-cycle completion pulse
//   inv_a                     inverter operand (no strobe; change restarts)
//   inv_res, inv_valid        inv_a^(p-2) mod p, level valid for current inv_a
// Build option: FE_INV_EN builds the inverter; without it inv_res and
// inv_valid are tied to 0 and inv_a is ignored.
module fe25519_arith
    import fe25519_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic add_start,
    input  fe_t  add_a,
    input  fe_t  add_b,
    output fe_t  add_res,
    output logic add_valid,
    input  logic mul_start,
    input  fe_t  mul_a,
    input  fe_t  mul_b,
    output fe_t  mul_res,
    output logic mul_valid,
    input  fe_t  inv_a,
    output fe_t  inv_res,
    output logic inv_valid
);

    // ---------------------------------------------------------------- adder
    // Sum < 2^256 <= 2p + 38, so two conditional subtractions reach [0, p).
    logic [FE_W:0] add_s0;
    logic [FE_W:0] add_s1;
    fe_t           add_sum;

    always_comb begin
        add_s0  = {1'b0, add_a} + {1'b0, add_b};
        add_s1  = reduce_once(add_s0);
        add_sum = fe_t'(reduce_once(add_s1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            add_res   <= '0;
            add_valid <= 1'b0;
        end else begin
            add_valid <= add_start;
            if (add_start) begin
                add_res <= add_sum;
            end
        end
    end

    // ----------------------------------------------------------- multiplier
    mul_state_t mul_state;

    fe_mul_serial u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (mul_start),
        .a     (mul_a),
        .b     (mul_b),
        .res   (mul_res),
        .valid (mul_valid),
        .state (mul_state)
    );

`ifdef FE_INV_EN
    // ------------------------------------------------------------- inverter
    // Square-and-multiply over the fixed exponent p-2, MSB first. The
    // exponent is a constant, so the sequence of operations (and hence the
    // latency) never depends on the operand.
    inv_state_t inv_state;
    inv_state_t inv_state_n;
    mul_state_t im_state;
    fe_t        inv_lat;
    fe_t        inv_r;
    fe_t        inv_res_q;
    logic       inv_done;
    logic [7:0] inv_idx;
    logic       inv_changed;
    logic       im_start;
    fe_t        im_a;
    fe_t        im_b;
    fe_t        im_res;
    logic       im_valid;

    assign inv_changed = (inv_a != inv_lat);
    assign inv_res     = inv_res_q;
    // Combinational so a new operand invalidates the result immediately.
    assign inv_valid   = inv_done && !inv_changed;

    fe_mul_serial u_inv_mul (
        .clk   (clk),
        .rst   (rst),
        .start (im_start),
        .a     (im_a),
        .b     (im_b),
        .res   (im_res),
        .valid (im_valid),
        .state (im_state)
    );

    // A pulse from an abandoned multiply can only arrive in INV_SQR, where
    // it is ignored; the next im_start then resets the multiplier.
    always_comb begin
        inv_state_n = inv_state;
        im_start    = 1'b0;
        im_a        = inv_r;
        im_b        = inv_r;
        if (inv_changed) begin
            inv_state_n = INV_SQR;
        end else begin
            case (inv_state)
                INV_IDLE: inv_state_n = INV_IDLE;
                INV_SQR: begin
                    im_start    = 1'b1;
                    inv_state_n = INV_SQR_WAIT;
                end
                INV_SQR_WAIT: begin
                    if (im_valid) begin
                        if (P_MINUS_2[inv_idx]) begin
                            inv_state_n = INV_MUL;
                        end else begin
                            inv_state_n = (inv_idx == 8'd0) ? INV_IDLE : INV_SQR;
                        end
                    end
                end
                INV_MUL: begin
                    im_start    = 1'b1;
                    im_b        = inv_lat;
                    inv_state_n = INV_MUL_WAIT;
                end
                INV_MUL_WAIT: begin
                    if (im_valid) begin
                        inv_state_n = (inv_idx == 8'd0) ? INV_IDLE : INV_SQR;
                    end
                end
                default: inv_state_n = INV_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inv_state <= INV_IDLE;
            inv_lat   <= '0;
            inv_r     <= '0;
            inv_res_q <= '0;
            inv_done  <= 1'b1;
            inv_idx   <= 8'd0;
        end else begin
            inv_state <= inv_state_n;
            if (inv_changed) begin
                inv_lat  <= inv_a;
                inv_done <= 1'b0;
                inv_r    <= fe_t'(1);
                inv_idx  <= 8'd254;
            end else if (im_valid &&
                         (inv_state == INV_SQR_WAIT || inv_state == INV_MUL_WAIT)) begin
                inv_r <= im_res;
                // A square on a set exponent bit is followed by a multiply
                // for the same bit; otherwise this bit is finished.
                if (inv_state == INV_MUL_WAIT || !P_MINUS_2[inv_idx]) begin
                    if (inv_idx == 8'd0) begin
                        inv_res_q <= im_res;
                        inv_done  <= 1'b1;
                    end else begin
                        inv_idx <= inv_idx - 8'd1;
                    end
                end
            end
        end
    end
`else
    logic unused_inv_a;
    assign unused_inv_a = ^inv_a;
    assign inv_res      = '0;
    assign inv_valid    = 1'b0;
`endif

endmodule

// File: tb/tb_fe25519_arith.sv
// tb_fe25519_arith
// Directed, table-driven bench for fe25519_arith: a vector table of
// concurrent add/mul operations with hand-computed results, then
// hand-written sequences for restart, abort, reset and inverter cases.
module tb_fe25519_arith;

    typedef logic [254:0] fe_t;

    localparam fe_t P      = {{250{1'b1}}, 5'b01101};
    localparam fe_t P_M1   = {{250{1'b1}}, 5'b01100};
    localparam fe_t P_M2   = {{250{1'b1}}, 5'b01011};
    localparam fe_t P_P1   = {{250{1'b1}}, 5'b01110};
    localparam fe_t ALL1   = {255{1'b1}};
    localparam fe_t TWO254 = {1'b1, 254'd0};
    localparam fe_t INV2   = {1'b0, {250{1'b1}}, 4'b0111};

    typedef struct {
        fe_t add_a;
        fe_t add_b;
        fe_t mul_a;
        fe_t mul_b;
        fe_t exp_add;
        fe_t exp_mul;
    } vec_t;

    logic clk;
    logic rst;
    logic add_start;
    fe_t  add_a;
    fe_t  add_b;
    fe_t  add_res;
    logic add_valid;
    logic mul_start;
    fe_t  mul_a;
    fe_t  mul_b;
    fe_t  mul_res;
    logic mul_valid;
    fe_t  inv_a;
    fe_t  inv_res;
    logic inv_valid;

    int n_checks;
    int n_err;
    int cyc;
    int pulses;
    int icyc;
    logic [254:0] exp_q[$];
    vec_t vecs[7];

    fe25519_arith dut (
        .clk       (clk),
        .rst       (rst),
        .add_start (add_start),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_res   (add_res),
        .add_valid (add_valid),
        .mul_start (mul_start),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_res   (mul_res),
        .mul_valid (mul_valid),
        .inv_a     (inv_a),
        .inv_res   (inv_res),
        .inv_valid (inv_valid)
    );

    // ------------------------------------------------------ clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // -------------------------------------------------------- check tasks
    task automatic check(input string name, input fe_t act, input fe_t exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard: compare mul_res against the oldest expected product.
    task automatic sb_pop(input string name);
        if (exp_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL %s: got mul_valid with no expected product", name);
        end else begin
            check(name, mul_res, exp_q.pop_front());
        end
    endtask

    // ------------------------------------------------------- driver tasks
    // Called on a falling edge; returns on the falling edge after the
    // rising edge that sampled the start strobes.
    task automatic start_ops(input logic do_add, input fe_t aa, input fe_t ab,
                             input logic do_mul, input fe_t ma, input fe_t mb,
                             input fe_t exp_mul);
        add_start = do_add;
        add_a     = aa;
        add_b     = ab;
        mul_start = do_mul;
        mul_a     = ma;
        mul_b     = mb;
        if (do_mul) begin
            // A new start replaces whatever was in flight.
            exp_q.delete();
            exp_q.push_back(exp_mul);
        end
        @(negedge clk);
        add_start = 1'b0;
        mul_start = 1'b0;
    endtask

    // Counts rising edges since the start edge until mul_valid; -1 on timeout.
    task automatic wait_mul(input int from, output int cycles);
        cycles = -1;
        for (int i = from + 1; i <= 400; i++) begin
            @(negedge clk);
            if (mul_valid === 1'b1) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic count_pulses(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (mul_valid === 1'b1) cnt++;
        end
    endtask

    // --------------------------------------------------------------- test
    initial begin
        n_checks  = 0;
        n_err     = 0;
        rst       = 1'b1;
        add_start = 1'b0;
        add_a     = '0;
        add_b     = '0;
        mul_start = 1'b0;
        mul_a     = '0;
        mul_b     = '0;
        inv_a     = '0;

        //            add_a   add_b      mul_a    mul_b     exp_add  exp_mul
        vecs[0] = '{P_M1,   255'd1,    255'd121666, 255'd2, 255'd0,  255'd243332};
        vecs[1] = '{ALL1,   ALL1,      P_M1,    P_M1,       255'd36, 255'd1};
        vecs[2] = '{255'd7, 255'd9,    255'd3,  255'd5,     255'd16, 255'd15};
        vecs[3] = '{P,      P,         ALL1,    ALL1,       255'd0,  255'd324};
        vecs[4] = '{P_M1,   P_M1,      P_P1,    255'd5,     P_M2,    255'd5};
        vecs[5] = '{255'd0, 255'd0,    TWO254,  255'd2,     255'd0,  255'd19};
        vecs[6] = '{TWO254, TWO254,    P_M1,    255'd2,     255'd19, P_M2};

        repeat (3) @(negedge clk);
        check("reset add_res", add_res, '0);
        check("reset mul_res", mul_res, '0);
        check("reset inv_res", inv_res, '0);
        check_bit("reset add_valid", add_valid, 1'b0);
        check_bit("reset mul_valid", mul_valid, 1'b0);
`ifdef FE_INV_EN
        check_bit("reset inv_valid", inv_valid, 1'b1);
`else
        check_bit("reset inv_valid", inv_valid, 1'b0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // Concurrent add + mul per vector; add result must hold through mul_valid.
        for (int i = 0; i < 7; i++) begin
            start_ops(1'b1, vecs[i].add_a, vecs[i].add_b,
                      1'b1, vecs[i].mul_a, vecs[i].mul_b, vecs[i].exp_mul);
            check_bit($sformatf("v%0d add_valid pulse", i), add_valid, 1'b1);
            check($sformatf("v%0d add_res", i), add_res, vecs[i].exp_add);
            check_bit($sformatf("v%0d no stale mul_valid", i), mul_valid, 1'b0);
            @(negedge clk);
            check_bit($sformatf("v%0d add_valid drops", i), add_valid, 1'b0);
            wait_mul(1, cyc);
            check_int($sformatf("v%0d mul latency", i), cyc, 256);
            sb_pop($sformatf("v%0d mul_res", i));
            check($sformatf("v%0d add_res held", i), add_res, vecs[i].exp_add);
            @(negedge clk);
            check_bit($sformatf("v%0d mul_valid drops", i), mul_valid, 1'b0);
            check($sformatf("v%0d mul_res held", i), mul_res, vecs[i].exp_mul);
        end

        // Back-to-back: new start on the cycle right after a pulse.
        start_ops(1'b0, '0, '0, 1'b1, 255'd3, 255'd5, 255'd15);
        wait_mul(0, cyc);
        check_int("b2b first latency", cyc, 256);
        sb_pop("b2b first mul_res");
        start_ops(1'b0, '0, '0, 1'b1, 255'd121666, 255'd2, 255'd243332);
        check_bit("b2b no stale pulse", mul_valid, 1'b0);
        wait_mul(0, cyc);
        check_int("b2b second latency", cyc, 256);
        sb_pop("b2b second mul_res");

        // Restart mid-run: exactly one pulse carrying the new product.
        start_ops(1'b0, '0, '0, 1'b1, ALL1, ALL1, 255'd324);
        repeat (100) @(negedge clk);
        start_ops(1'b0, '0, '0, 1'b1, 255'd7, 255'd9, 255'd63);
        check_bit("restart no pulse", mul_valid, 1'b0);
        wait_mul(0, cyc);
        check_int("restart latency", cyc, 256);
        sb_pop("restart mul_res");
        count_pulses(300, pulses);
        check_int("restart extra pulses", pulses, 0);

        // Restart in the final cycle: aborted result must not appear.
        start_ops(1'b0, '0, '0, 1'b1, P_M1, P_M1, 255'd1);
        repeat (255) @(negedge clk);
        check_bit("fin no early pulse", mul_valid, 1'b0);
        start_ops(1'b0, '0, '0, 1'b1, P_P1, 255'd5, 255'd5);
        check_bit("fin abort no pulse", mul_valid, 1'b0);
        check("fin abort res unchanged", mul_res, 255'd63);
        wait_mul(0, cyc);
        check_int("fin restart latency", cyc, 256);
        sb_pop("fin restart mul_res");

        // Reset mid-operation.
        start_ops(1'b1, 255'd7, 255'd9, 1'b1, 255'd3, 255'd5, 255'd15);
        repeat (100) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        check("rst add_res", add_res, '0);
        check("rst mul_res", mul_res, '0);
        check_bit("rst mul_valid", mul_valid, 1'b0);
        count_pulses(300, pulses);
        check_int("rst no pulse", pulses, 0);
        start_ops(1'b0, '0, '0, 1'b1, 255'd121666, 255'd2, 255'd243332);
        wait_mul(0, cyc);
        check_int("post-rst latency", cyc, 256);
        sb_pop("post-rst mul_res");

        // Reset on the completion edge overrides the pulse.
        @(negedge clk);
        start_ops(1'b0, '0, '0, 1'b1, 255'd3, 255'd5, 255'd15);
        repeat (255) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        check_bit("rst at completion no pulse", mul_valid, 1'b0);
        check("rst at completion mul_res", mul_res, '0);

        // Inverter.
`ifdef FE_INV_EN
        check_bit("inv0 valid", inv_valid, 1'b1);
        check("inv0 res", inv_res, '0);
        inv_a = 255'd2;
        #1;
        check_bit("inv change drops valid", inv_valid, 1'b0);
        icyc = -1;
        for (int i = 1; i <= 200000; i++) begin
            @(negedge clk);
            if (inv_valid === 1'b1) begin
                icyc = i;
                break;
            end
        end
        check_bit("inv2 completes", icyc > 0, 1'b1);
        check("inv2 res", inv_res, INV2);
        inv_a = 255'd3;
        #1;
        check_bit("inv3 drops valid", inv_valid, 1'b0);
        repeat (1000) @(negedge clk);
        rst   = 1'b1;
        inv_a = '0;
        @(negedge clk);
        rst = 1'b0;
        check("inv rst res", inv_res, '0);
        @(negedge clk);
        check_bit("inv rst valid for 0", inv_valid, 1'b1);
`else
        inv_a = 255'd2;
        #1;
        check_bit("inv disabled valid", inv_valid, 1'b0);
        @(negedge clk);
        check("inv disabled res", inv_res, '0);
        check_bit("inv disabled valid later", inv_valid, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
